// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch resolution sequencer: flag register, hazard stall, PC redirect, wrong-path flush, taken counter
// Optional feature macro: BRANCH_FLAG_FWD_EN (forward EX flags into IDLE evaluation, never stall)
module branch_ctrl #(
  parameter int PC_W         = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             brValid,
  input  logic [2:0]       brOp,
  input  logic [PC_W-1:0]  brTarget,
  input  logic             flagWe,
  input  logic             aluN,
  input  logic             aluZ,
  input  logic             aluV,
  output logic             stall,
  output logic             pcSrc,
  output logic [PC_W-1:0]  pcTarget,
  output logic             flush,
  output logic             flagN,
  output logic             flagZ,
  output logic             flagV,
  output logic [CNT_W-1:0] takenCnt
);

  localparam logic [2:0] OP_BNEQ    = 3'b000;
  localparam logic [2:0] OP_BEQ     = 3'b001;
  localparam logic [2:0] OP_BGT     = 3'b010;
  localparam logic [2:0] OP_BLT     = 3'b011;
  localparam logic [2:0] OP_BGTE    = 3'b100;
  localparam logic [2:0] OP_BLTE    = 3'b101;
  localparam logic [2:0] OP_BOVFL   = 3'b110;
  localparam logic [2:0] OP_BUNCOND = 3'b111;

  // Flush counter is loaded with the number of extra flush cycles after the first.
  localparam logic [3:0] FCNT_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_flag_n;
  logic              r_flag_z;
  logic              r_flag_v;
  logic [3:0]        r_fcnt;
  logic              r_pc_src;
  logic [PC_W-1:0]   r_pc_target;
  logic              r_flush;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_take;
  logic [PC_W-1:0]   w_take_target;
  logic              w_stall;

`ifndef BRANCH_FLAG_FWD_EN
  logic [2:0]        r_op;
  logic [PC_W-1:0]   r_target;
  logic              w_capture;
`endif

  function automatic logic f_taken(input logic [2:0] op, input logic n, input logic z, input logic v);
    logic t;
    t = 1'b0;
    case (op)
      OP_BNEQ:    t = ~z;
      OP_BEQ:     t = z;
      OP_BGT:     t = ~z & ~n;
      OP_BLT:     t = n;
      OP_BGTE:    t = ~n;
      OP_BLTE:    t = n | z;
      OP_BOVFL:   t = v;
      OP_BUNCOND: t = 1'b1;
      default:    t = 1'b0;
    endcase
    return t;
  endfunction

  // Next-state, stall and branch decision; stall depends only on state, brValid and flagWe.
  always_comb begin
    w_state_nxt   = r_state;
    w_take        = 1'b0;
    w_take_target = brTarget;
    w_stall       = 1'b0;
`ifndef BRANCH_FLAG_FWD_EN
    w_capture     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (brValid) begin
`ifdef BRANCH_FLAG_FWD_EN
          if (flagWe) begin
            w_take = f_taken(brOp, aluN, aluZ, aluV);
          end else begin
            w_take = f_taken(brOp, r_flag_n, r_flag_z, r_flag_v);
          end
`else
          if (flagWe) begin
            // Flags still in flight: hold ID one cycle and resolve from STALL.
            w_stall     = 1'b1;
            w_capture   = 1'b1;
            w_state_nxt = S_STALL;
          end else begin
            w_take = f_taken(brOp, r_flag_n, r_flag_z, r_flag_v);
          end
`endif
          if (w_take) begin
            w_state_nxt = S_FLUSH;
          end
        end
      end
      S_STALL: begin
`ifdef BRANCH_FLAG_FWD_EN
        w_state_nxt = S_IDLE;
`else
        // Register already holds the hazard's flags; this cycle's flagWe lands too late to matter.
        w_take        = f_taken(r_op, r_flag_n, r_flag_z, r_flag_v);
        w_take_target = r_target;
        w_state_nxt   = w_take ? S_FLUSH : S_IDLE;
`endif
      end
      S_FLUSH: begin
        if (r_fcnt == 4'd0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Architectural flags follow the EX ALU whenever it writes, regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (flagWe) begin
      r_flag_n <= aluN;
      r_flag_z <= aluZ;
      r_flag_v <= aluV;
    end
  end

`ifndef BRANCH_FLAG_FWD_EN
  // Hold the stalled branch's condition and target for evaluation in STALL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 3'b000;
      r_target <= '0;
    end else if (w_capture) begin
      r_op     <= brOp;
      r_target <= brTarget;
    end
  end
`endif

  // Redirect pulse, flush window and saturating taken-branch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_src    <= 1'b0;
      r_pc_target <= '0;
      r_flush     <= 1'b0;
      r_fcnt      <= 4'd0;
      r_cnt       <= '0;
    end else if (w_take) begin
      r_pc_src    <= 1'b1;
      r_pc_target <= w_take_target;
      r_flush     <= 1'b1;
      r_fcnt      <= FCNT_INIT;
      if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end else begin
      r_pc_src <= 1'b0;
      if (r_state == S_FLUSH) begin
        if (r_fcnt == 4'd0) begin
          r_flush <= 1'b0;
        end else begin
          r_fcnt <= r_fcnt - 4'd1;
        end
      end
    end
  end

  assign stall    = w_stall;
  assign pcSrc    = r_pc_src;
  assign pcTarget = r_pc_target;
  assign flush    = r_flush;
  assign flagN    = r_flag_n;
  assign flagZ    = r_flag_z;
  assign flagV    = r_flag_v;
  assign takenCnt = r_cnt;

endmodule
